// File: rtl/ram_bus_ctrl.sv
// Bus-owning controller for a single-port synchronous RAM: one request at a time, registered strobes.
// Define RAM_CTRL_BURST_EN to honour req_len for 1-4 beat read bursts.
`ifndef B_SIZE
`define B_SIZE 16
`endif

module ram_bus_ctrl #(
    parameter int unsigned DATA_W = `B_SIZE,
    parameter int unsigned ADDR_W = `B_SIZE - 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    inout  wire  [DATA_W-1:0] ram_data
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdAddr,
        StRdData,
        StTurn
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic                oe_q, oe_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_last_q, rsp_last_d;
    logic                beat_last;

`ifdef RAM_CTRL_BURST_EN
    logic [1:0]          cnt_q, cnt_d;
`else
    logic                unused_len;
    assign unused_len = ^req_len;
`endif

    assign req_ready = (state_q == StIdle) && !rst;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
`ifdef RAM_CTRL_BURST_EN
        cnt_d       = cnt_q;
        beat_last   = (cnt_q == 2'd0);
`else
        beat_last   = 1'b1;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? StWrite : StRdAddr;
`ifdef RAM_CTRL_BURST_EN
                    cnt_d   = req_len;
`endif
                end
            end
            StWrite: state_d = StIdle;
            StRdAddr: begin
                // Present a+1 during the first data beat so the RAM pipelines the next word.
                addr_d  = addr_q + 1'b1;
                state_d = StRdData;
            end
            StRdData: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = ram_data;
                rsp_last_d  = beat_last;
                addr_d      = addr_q + 1'b1;
                if (beat_last) begin
                    state_d = StTurn;
                end
`ifdef RAM_CTRL_BURST_EN
                else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        cs_d = (state_d == StWrite) || (state_d == StRdAddr) || (state_d == StRdData);
        we_d = (state_d == StWrite);
        oe_d = (state_d == StRdData);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
`ifdef RAM_CTRL_BURST_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
`ifdef RAM_CTRL_BURST_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign ram_addr  = addr_q;
    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_oe    = oe_q;
    assign ram_data  = (cs_q && we_q) ? wdata_q : {DATA_W{1'bz}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Self-checking bench for ram_bus_ctrl: behavioural RAM, shadow-memory reference, random traffic.
module tb_ram_bus_ctrl;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int Words = 1 << AW;
`ifdef RAM_CTRL_BURST_EN
    localparam bit BurstEn = 1'b1;
`else
    localparam bit BurstEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    req_len;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic          ram_we;
    logic          ram_oe;
    wire  [DW-1:0] ram_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem    [Words];
    logic [DW-1:0] shadow [Words];
    logic [DW-1:0] ram_rd_q;

    ram_bus_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .ram_data  (ram_data)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read; drives the bus only while output-enabled.
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] = ram_data;
        if (ram_cs && !ram_we) ram_rd_q <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : {DW{1'bz}};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; presents the request, waits for acceptance and checks the whole transaction.
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [1:0] len);
        int            waited;
        int            n;
        logic [AW-1:0] ba;
        bit            exp_v;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_len   = len;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
        req_len   = 2'($urandom);
        if (we) begin
            @(negedge clk);
            check_eq("wr_cs", ram_cs, 1);
            check_eq("wr_we", ram_we, 1);
            check_eq("wr_oe", ram_oe, 0);
            check_eq("wr_addr", ram_addr, a);
            check_eq("wr_data", ram_data, wd);
            check_eq("wr_ready", req_ready, 0);
            check_eq("wr_rsp_valid", rsp_valid, 0);
            shadow[a] = wd;
            @(negedge clk);
            check_eq("wr_done_cs", ram_cs, 0);
            check_eq("wr_done_we", ram_we, 0);
            check_eq("wr_done_ready", req_ready, 1);
        end else begin
            n = BurstEn ? int'(len) + 1 : 1;
            for (int j = 0; j <= n + 2; j++) begin
                @(negedge clk);
                exp_v = (j >= 2) && (j <= n + 1);
                check_eq("rd_cs", ram_cs, (j <= n));
                check_eq("rd_oe", ram_oe, (j >= 1 && j <= n));
                check_eq("rd_we", ram_we, 0);
                check_eq("rd_ready", req_ready, (j == n + 2));
                check_eq("rd_rsp_valid", rsp_valid, exp_v);
                if (j == 0) check_eq("rd_addr", ram_addr, a);
                if (exp_v) begin
                    ba = a + AW'(j - 2);
                    check_eq("rd_data", rsp_data, shadow[ba]);
                    check_eq("rd_last", rsp_last, (j - 2 == n - 1));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rst_j;
        logic [AW-1:0] a;
        for (int i = 0; i < Words; i++) begin
            mem[i]    = DW'(i) ^ 16'h5A5A;
            shadow[i] = DW'(i) ^ 16'h5A5A;
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_cs", ram_cs, 0);
        check_eq("rst_we", ram_we, 0);
        check_eq("rst_oe", ram_oe, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_last", rsp_last, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_addr", ram_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", req_ready, 1);

        do_req(1'b1, 13'h0005, 16'hBEEF, 2'd0);
        do_req(1'b0, 13'h0005, 16'h0000, 2'd0);
        do_req(1'b1, 13'h0006, 16'h1234, 2'd0);
        do_req(1'b0, 13'h0006, 16'h0000, 2'd3);

        do_req(1'b1, 13'h1FFE, 16'h000A, 2'd1);
        do_req(1'b1, 13'h1FFF, 16'h000B, 2'd2);
        do_req(1'b1, 13'h0000, 16'h000C, 2'd3);
        do_req(1'b0, 13'h1FFE, 16'h0000, BurstEn ? 2'd2 : 2'd3);

        // Reset in the middle of a read's data phase.
        rst_j     = BurstEn ? 2 : 1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 13'h0100;
        req_len   = 2'd3;
        check_eq("mid_accept_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int j = 0; j <= rst_j; j++) @(negedge clk);
        rst = 1'b1;
        #1 check_eq("mid_rst_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq("mid_rst_rsp_valid", rsp_valid, 0);
            check_eq("mid_rst_cs", ram_cs, 0);
            check_eq("mid_rst_oe", ram_oe, 0);
            check_eq("mid_rst_ready", req_ready, 1);
        end
        do_req(1'b1, 13'h0010, 16'hC0DE, 2'd2);
        do_req(1'b0, 13'h0010, 16'h0000, 2'd0);

        // Random traffic around the top-of-memory wrap point and a low window.
        for (int t = 0; t < 80; t++) begin
            a = ($urandom_range(0, 1) == 0) ? 13'h1FFC + AW'($urandom_range(0, 7))
                                            : 13'h0040 + AW'($urandom_range(0, 7));
            do_req(1'($urandom), a, DW'($urandom), 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
